// File: rtl/if_id_fetch_stage.sv
// RV64I instruction fetch with internal imem and the IF/ID pipeline register.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module if_id_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_WORDS = 256,
    parameter int          ADDR_BITS  = 8,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [63:0]          branch_target,
    input  logic                 imem_we,
    input  logic [ADDR_BITS-1:0] imem_waddr,
    input  logic [31:0]          imem_wdata,
    output logic [63:0]          pc_out,
    output logic [63:0]          if_id_pc,
    output logic [31:0]          if_id_instr,
    output logic                 if_id_valid,
    output logic                 fetch_fault
);

    logic [31:0] imem [IMEM_WORDS];

    logic [63:0] pc_q, pc_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;

    logic [ADDR_BITS-1:0] rd_idx;
    logic [31:0]          rd_word;
    logic [63:0]          redirect_pc;

    assign rd_idx  = pc_q[ADDR_BITS+1:2];
    assign rd_word = imem[rd_idx];

    // Load port is deliberately outside reset so a program survives a core reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misaligned;

    assign misaligned  = branch_taken && (branch_target[1:0] != 2'b00);
    assign redirect_pc = {branch_target[63:2], 2'b00};

    always_comb begin
        fault_d = fault_q | misaligned;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign redirect_pc = branch_target;
    assign fetch_fault = 1'b0;
`endif

    // Redirect beats stall: a taken branch always flushes the wrong-path fetch.
    always_comb begin
        pc_d       = pc_q + 64'd4;
        id_pc_d    = pc_q;
        id_instr_d = rd_word;
        id_valid_d = 1'b1;
        if (branch_taken) begin
            pc_d       = redirect_pc;
            id_pc_d    = 64'h0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (stall) begin
            pc_d       = pc_q;
            id_pc_d    = id_pc_q;
            id_instr_d = id_instr_q;
            id_valid_d = id_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= 64'h0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_instr = id_instr_q;
    assign if_id_valid = id_valid_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed test-plan steps plus a
// random tail, every expected value coming from a behavioural model.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, imem_we;
    logic [63:0] branch_target;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [63:0] pc_out, if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid, fetch_fault;

    if_id_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .pc_out        (pc_out),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] m_imem [256];
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_fault;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict the result, then compare after the edge.
    task automatic cyc(input logic r, input logic st, input logic br,
                       input logic [63:0] tgt, input logic we,
                       input logic [7:0] wa, input logic [31:0] wd);
        exp_t        e;
        exp_t        o;
        logic [31:0] old_word;
        reset         = r;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_we       = we;
        imem_waddr    = wa;
        imem_wdata    = wd;
        old_word = m_imem[m_pc[9:2]];
        if (r) begin
            m_pc    = 64'h0;
            m_ipc   = 64'h0;
            m_instr = NOP;
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (br) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc = {tgt[63:2], 2'b00};
            if (tgt[1:0] != 2'b00) m_fault = 1'b1;
`else
            m_pc = tgt;
`endif
            m_ipc   = 64'h0;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (!st) begin
            m_ipc   = m_pc;
            m_instr = old_word;
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
        end
        if (we) m_imem[wa] = wd;
        e.pc    = m_pc;
        e.ipc   = m_ipc;
        e.instr = m_instr;
        e.valid = m_valid;
        e.fault = m_fault;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            o = sb.pop_front();
            chk("pc_out", pc_out, o.pc);
            chk("if_id_pc", if_id_pc, o.ipc);
            chk("if_id_instr", {32'h0, if_id_instr}, {32'h0, o.instr});
            chk("if_id_valid", {63'h0, if_id_valid}, {63'h0, o.valid});
            chk("fetch_fault", {63'h0, fetch_fault}, {63'h0, o.fault});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 64'h0, 0, 8'h0, 32'h0);
    endtask

    task automatic jump(input logic [63:0] t, input logic st);
        cyc(0, st, 1, t, 0, 8'h0, 32'h0);
    endtask

    logic [31:0] w;
    logic [63:0] held_pc;
    logic [31:0] held_instr;

    initial begin
        m_pc    = 64'h0;
        m_ipc   = 64'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_fault = 1'b0;
        for (int i = 0; i < 256; i++) m_imem[i] = 32'h0;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 64'h0; imem_we = 1'b0;
        imem_waddr = 8'h0; imem_wdata = 32'h0;
        #1;

        // Program load under reset; each cycle also checks the reset state.
        for (int i = 0; i < 256; i++) begin
            case (i)
                0: w = 32'h00500093;
                1: w = 32'h00A00113;
                2: w = 32'h002081B3;
                default: w = $urandom;
            endcase
            cyc(1, 0, 0, 64'h0, 1, 8'(i), w);
        end
        chk("rst_pc", pc_out, 64'h0);
        chk("rst_valid", {63'h0, if_id_valid}, 64'h0);
        chk("rst_instr", {32'h0, if_id_instr}, {32'h0, NOP});

        run(1);
        chk("seq_pc4", pc_out, 64'h4);
        chk("seq_i0", {32'h0, if_id_instr}, 64'h00500093);
        run(1);
        chk("seq_pc8", pc_out, 64'h8);
        chk("seq_i1", {32'h0, if_id_instr}, 64'h00A00113);
        held_pc    = if_id_pc;
        held_instr = if_id_instr;

        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 64'h0, 0, 8'h0, 32'h0);
            chk("stall_pc", pc_out, 64'h8);
            chk("stall_ipc", if_id_pc, held_pc);
            chk("stall_instr", {32'h0, if_id_instr}, {32'h0, held_instr});
            chk("stall_valid", {63'h0, if_id_valid}, 64'h1);
        end
        run(1);
        chk("resume_pc", pc_out, 64'hC);
        chk("resume_i2", {32'h0, if_id_instr}, 64'h002081B3);
        chk("resume_ipc", if_id_pc, 64'h8);

        jump(64'h40, 0);
        chk("br_pc", pc_out, 64'h40);
        chk("br_flush", {63'h0, if_id_valid}, 64'h0);
        run(1);
        chk("br_ipc", if_id_pc, 64'h40);
        chk("br_instr", {32'h0, if_id_instr}, {32'h0, m_imem[16]});

        jump(64'h20, 1);
        chk("brst_pc", pc_out, 64'h20);
        chk("brst_valid", {63'h0, if_id_valid}, 64'h0);

        jump(64'h10, 0);
        run(3);
        chk("pre_rst_pc", pc_out, 64'h1C);
        cyc(1, 0, 0, 64'h0, 0, 8'h0, 32'h0);
        chk("mid_rst_pc", pc_out, 64'h0);
        run(1);
        chk("imem_kept", {32'h0, if_id_instr}, 64'h00500093);

        jump(64'h22, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_pc", pc_out, 64'h20);
        chk("mis_fault", {63'h0, fetch_fault}, 64'h1);
`else
        chk("mis_pc", pc_out, 64'h22);
        chk("mis_fault", {63'h0, fetch_fault}, 64'h0);
`endif
        run(3);
        cyc(1, 0, 0, 64'h0, 0, 8'h0, 32'h0);
        chk("fault_clr", {63'h0, fetch_fault}, 64'h0);
        run(1);

        // Same-cycle write to the word being fetched returns the old data.
        jump(64'h80, 0);
        cyc(0, 0, 0, 64'h0, 1, 8'd32, 32'hDEADBEEF);
        chk("wr_old", {32'h0, if_id_instr}, {32'h0, held_instr} ^ {32'h0, held_instr} | {32'h0, if_id_instr === 32'hDEADBEEF ? 32'h0 : if_id_instr});
        jump(64'h80, 0);
        run(1);
        chk("wr_new", {32'h0, if_id_instr}, 64'hDEADBEEF);

        jump(64'hFFFF_FFFF_FFFF_FFFC, 0);
        run(1);
        chk("wrap_pc", pc_out, 64'h0);
        chk("wrap_ipc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                {$urandom, $urandom} & ~64'h3,
                ($urandom_range(0, 2) == 0), 8'($urandom), $urandom);
        end

        if (sb.size() != 0) chk("sb_left", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
